apb_initiator: RTL and testbench
================================

Name: apb_initiator

Overview:
- Bridges the core's load/store port onto the APB initiator port of the fabric (core_i_* side).
- Converts a valid/ready request and response pair into APB4 SETUP and ACCESS phases, one transfer at a time.
- Holds the response until the core accepts it.
- Optional timeout aborts an ACCESS phase that never completes and reports an error.

Parameters:
ADDR_W, 32, APB address width
TIMEOUT, 0, max ACCESS cycles waiting for pready before abort; 0 = never time out

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  core request valid
req_ready  out  1  bridge can accept request
req_addr  in  ADDR_W  byte address
req_write  in  1  1 = write, 0 = read
req_wdata  in  32  write data
req_wstrb  in  4  byte strobes
rsp_valid  out  1  response valid
rsp_ready  in  1  core accepts response
rsp_rdata  out  32  read data (0 for writes/errors)
rsp_err  out  1  pslverr or timeout
apb_i_psel  out  1  APB select
apb_i_penable  out  1  APB enable
apb_i_pready  in  1  APB ready
apb_i_paddr  out  ADDR_W  APB address
apb_i_pwrite  out  1  APB write
apb_i_pwdata  out  32  APB write data
apb_i_pwstrb  out  4  APB strobes
apb_i_prdata  in  32  APB read data
apb_i_pslverr  in  1  APB slave error

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. All state and registered outputs clear immediately on assertion.
- Reset values:
  - FSM = IDLE.
  - psel, penable, pwrite, rsp_valid, rsp_err = 0.
  - paddr, pwdata, pwstrb, rsp_rdata = 0.
  - Timeout counter = 0.
  - req_ready = 1 (combinational: FSM == IDLE).
- All apb_i_* outputs and rsp_* outputs are registered; no combinational path from APB inputs to outputs.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch addr, write and wdata into paddr/pwrite/pwdata.
  - Latch pwstrb = req_write ? req_wstrb : 4'h0 (APB4 read rule).
  - Set psel=1, penable=0; next state SETUP.
- SETUP (1 cycle): penable<=1; next state ACCESS. paddr/pwrite/pwdata/pwstrb stay stable from SETUP through end of ACCESS.
- ACCESS:
  - psel=1, penable=1.
  - On pready=1:
    - rsp_rdata <= pwrite ? 0 : prdata.
    - rsp_err <= pslverr; if pslverr=1 then rsp_rdata <= 0.
    - psel<=0, penable<=0, rsp_valid<=1; next state RESP.
  - Otherwise the counter increments.
- Timeout: if TIMEOUT>0 and the counter reaches TIMEOUT-1 with pready=0:
  - rsp_err<=1, rsp_rdata<=0, psel<=0, penable<=0, rsp_valid<=1; next state RESP.
  - pready arriving on that same cycle wins: normal completion, no timeout.
- Counter: width $clog2(TIMEOUT+1), minimum 1. Cleared on entry to ACCESS. It cannot wrap because it is bounded by TIMEOUT-1.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err stable until accepted.
  - On rsp_ready: rsp_valid<=0; next state IDLE.
  - req_ready=0 throughout; requests wait.
- Latency: request accepted at cycle 0, SETUP at cycle 1, ACCESS at cycle 2. With zero-wait pready, rsp_valid is high at cycle 3. Each pready wait state adds 1 cycle.
- Throughput: minimum 4 cycles per transfer when rsp_ready is tied high (IDLE, SETUP, ACCESS, RESP).
- Boundaries:
  - req_valid while not IDLE is ignored; the request must be held until req_ready.
  - rsp_ready while not in RESP is ignored.
  - Reset asserted mid-transfer: psel/penable drop immediately; no response is produced.
  - pslverr is sampled only when penable & pready.

Test Plan:
1. Zero-wait read: req addr=0x0000_1000 read; target pready=1, prdata=0xDEADBEEF. Expect:
   - psel high at cycles 1–2, penable high at cycle 2 only, pwstrb=0.
   - rsp_valid at cycle 3 with rdata=0xDEADBEEF, err=0.
2. Write with 3 wait states: addr=0x8000_0004, wdata=0x41, wstrb=4'b0001. Expect:
   - paddr/pwdata/pwstrb stable for all 5 psel cycles.
   - rsp_valid at cycle 6, rdata=0, err=0.
3. Slave error on read: pready=1, pslverr=1, prdata=0x1234 → rsp_err=1, rsp_rdata=0.
4. Timeout (TIMEOUT=4), pready stuck at 0. Expect:
   - penable high for exactly 4 cycles, then psel and penable drop.
   - rsp_err=1. With pready=1 arriving on the 4th ACCESS cycle instead: normal response, err=0.
5. Response backpressure: rsp_ready=0 for 5 cycles while a second req_valid is held.
   - rsp_valid, rdata and err stay stable; req_ready=0.
   - The second request is accepted 1 cycle after rsp_ready=1.
6. Reset during ACCESS: deassert rst_n with pready=0. Expect:
   - psel=0, penable=0, rsp_valid=0 immediately.
   - After release: req_ready=1 and a new transfer completes normally.

Source files
------------

// File: rtl/apb_initiator.sv
// Bridge from the core's valid/ready load/store port to an APB4 initiator port.
// One transfer in flight; optional ACCESS-phase timeout reports an error response.
module apb_initiator #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_write,
   input  logic [31:0]       req_wdata,
   input  logic [3:0]        req_wstrb,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              apb_i_psel,
   output logic              apb_i_penable,
   input  logic              apb_i_pready,
   output logic [ADDR_W-1:0] apb_i_paddr,
   output logic              apb_i_pwrite,
   output logic [31:0]       apb_i_pwdata,
   output logic [3:0]        apb_i_pwstrb,
   input  logic [31:0]       apb_i_prdata,
   input  logic              apb_i_pslverr
);

   localparam int CNT_W_RAW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int CNT_W     = (CNT_W_RAW > 1) ? CNT_W_RAW : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;

   assign req_ready = (state_r == IDLE);

   // Transfer sequencer: owns every APB and response output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         cnt_r         <= '0;
         apb_i_psel    <= 1'b0;
         apb_i_penable <= 1'b0;
         apb_i_paddr   <= '0;
         apb_i_pwrite  <= 1'b0;
         apb_i_pwdata  <= 32'h0000_0000;
         apb_i_pwstrb  <= 4'h0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= 32'h0000_0000;
         rsp_err       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (req_valid) begin
                  apb_i_paddr   <= req_addr;
                  apb_i_pwrite  <= req_write;
                  apb_i_pwdata  <= req_wdata;
                  // APB4 requires all strobes low on reads
                  apb_i_pwstrb  <= req_write ? req_wstrb : 4'h0;
                  apb_i_psel    <= 1'b1;
                  apb_i_penable <= 1'b0;
                  state_r       <= SETUP;
               end
            end
            SETUP: begin
               apb_i_penable <= 1'b1;
               cnt_r         <= '0;
               state_r       <= ACCESS;
            end
            ACCESS: begin
               if (apb_i_pready) begin
                  rsp_rdata     <= (apb_i_pwrite || apb_i_pslverr) ? 32'h0000_0000 : apb_i_prdata;
                  rsp_err       <= apb_i_pslverr;
                  apb_i_psel    <= 1'b0;
                  apb_i_penable <= 1'b0;
                  rsp_valid     <= 1'b1;
                  state_r       <= RESP;
               end else if ((TIMEOUT > 0) && (cnt_r == CNT_LAST)) begin
                  rsp_rdata     <= 32'h0000_0000;
                  rsp_err       <= 1'b1;
                  apb_i_psel    <= 1'b0;
                  apb_i_penable <= 1'b0;
                  rsp_valid     <= 1'b1;
                  state_r       <= RESP;
               end else if (TIMEOUT > 0) begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state_r   <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_initiator.sv
// Directed bench for apb_initiator (TIMEOUT=4): latency, wait states, errors,
// timeout, response backpressure and reset during ACCESS.
module tb_apb_initiator;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_write;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        psel;
   logic        penable;
   logic        pready;
   logic [31:0] paddr;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pwstrb;
   logic [31:0] prdata;
   logic        pslverr;

   int n_tests = 0;
   int n_fail  = 0;

   apb_initiator #(.ADDR_W(32), .TIMEOUT(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .req_write     (req_write),
      .req_wdata     (req_wdata),
      .req_wstrb     (req_wstrb),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_rdata     (rsp_rdata),
      .rsp_err       (rsp_err),
      .apb_i_psel    (psel),
      .apb_i_penable (penable),
      .apb_i_pready  (pready),
      .apb_i_paddr   (paddr),
      .apb_i_pwrite  (pwrite),
      .apb_i_pwdata  (pwdata),
      .apb_i_pwstrb  (pwstrb),
      .apb_i_prdata  (prdata),
      .apb_i_pslverr (pslverr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a request for exactly one edge; returns in cycle 1 (SETUP).
   task automatic send(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
      req_addr  = a;
      req_write = w;
      req_wdata = d;
      req_wstrb = s;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      req_addr  = 32'hFFFF_FFFF;
      req_wdata = 32'hFFFF_FFFF;
   endtask

   task automatic accept();
      rsp_ready = 1'b1;
      tick();
      chk("accept_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("accept_req_ready", {31'd0, req_ready}, 32'd1);
      rsp_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_write = 1'b0;
      req_wdata = 32'h0; req_wstrb = 4'h0; rsp_ready = 1'b0;
      pready = 1'b0; prdata = 32'h0; pslverr = 1'b0;
      #2;
      chk("rst_psel", {31'd0, psel}, 32'd0);
      chk("rst_penable", {31'd0, penable}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_paddr", paddr, 32'h0);
      chk("rst_rdata", rsp_rdata, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // 1: zero-wait read
      pready = 1'b1; prdata = 32'hDEAD_BEEF;
      send(32'h0000_1000, 1'b0, 32'h55, 4'hF);
      chk("t1_c1_psel", {31'd0, psel}, 32'd1);
      chk("t1_c1_penable", {31'd0, penable}, 32'd0);
      chk("t1_c1_pwstrb", {28'd0, pwstrb}, 32'h0);
      chk("t1_c1_paddr", paddr, 32'h0000_1000);
      chk("t1_c1_req_ready", {31'd0, req_ready}, 32'd0);
      tick();
      chk("t1_c2_psel", {31'd0, psel}, 32'd1);
      chk("t1_c2_penable", {31'd0, penable}, 32'd1);
      chk("t1_c2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      tick();
      chk("t1_c3_psel", {31'd0, psel}, 32'd0);
      chk("t1_c3_penable", {31'd0, penable}, 32'd0);
      chk("t1_c3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("t1_c3_rdata", rsp_rdata, 32'hDEAD_BEEF);
      chk("t1_c3_err", {31'd0, rsp_err}, 32'd0);
      accept();

      // 2: write, 3 wait states; pready lands on 4th ACCESS cycle (cnt = TIMEOUT-1)
      pready = 1'b0; prdata = 32'h0000_FFFF;
      send(32'h8000_0004, 1'b1, 32'h41, 4'b0001);
      chk("t2_c1_psel", {31'd0, psel}, 32'd1);
      chk("t2_c1_penable", {31'd0, penable}, 32'd0);
      for (int c = 2; c <= 5; c++) begin
         tick();
         chk("t2_acc_psel", {31'd0, psel}, 32'd1);
         chk("t2_acc_penable", {31'd0, penable}, 32'd1);
         chk("t2_acc_paddr", paddr, 32'h8000_0004);
         chk("t2_acc_pwdata", pwdata, 32'h41);
         chk("t2_acc_pwstrb", {28'd0, pwstrb}, 32'h1);
         chk("t2_acc_pwrite", {31'd0, pwrite}, 32'd1);
         chk("t2_acc_rsp_valid", {31'd0, rsp_valid}, 32'd0);
         pready = (c == 5);
      end
      tick();
      pready = 1'b0;
      chk("t2_c6_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("t2_c6_psel", {31'd0, psel}, 32'd0);
      chk("t2_c6_rdata", rsp_rdata, 32'h0);
      chk("t2_c6_err", {31'd0, rsp_err}, 32'd0);
      accept();

      // 3: slave error on read
      pready = 1'b1; pslverr = 1'b1; prdata = 32'h0000_1234;
      send(32'h0000_2000, 1'b0, 32'h0, 4'h0);
      tick();
      tick();
      chk("t3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("t3_err", {31'd0, rsp_err}, 32'd1);
      chk("t3_rdata", rsp_rdata, 32'h0);
      pslverr = 1'b0;
      accept();

      // 4a: timeout with pready stuck low
      pready = 1'b0; prdata = 32'h7777_7777;
      send(32'h0000_3000, 1'b0, 32'h0, 4'h0);
      chk("t4a_c1_penable", {31'd0, penable}, 32'd0);
      for (int c = 2; c <= 5; c++) begin
         tick();
         chk("t4a_acc_penable", {31'd0, penable}, 32'd1);
         chk("t4a_acc_psel", {31'd0, psel}, 32'd1);
      end
      tick();
      chk("t4a_psel_drop", {31'd0, psel}, 32'd0);
      chk("t4a_penable_drop", {31'd0, penable}, 32'd0);
      chk("t4a_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("t4a_err", {31'd0, rsp_err}, 32'd1);
      chk("t4a_rdata", rsp_rdata, 32'h0);
      accept();

      // 4b: pready arrives on the 4th ACCESS cycle, completion wins over timeout
      prdata = 32'hCAFE_0001;
      send(32'h0000_3004, 1'b0, 32'h0, 4'h0);
      for (int c = 2; c <= 5; c++) begin
         tick();
         chk("t4b_acc_penable", {31'd0, penable}, 32'd1);
         pready = (c == 5);
      end
      tick();
      pready = 1'b0;
      chk("t4b_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("t4b_err", {31'd0, rsp_err}, 32'd0);
      chk("t4b_rdata", rsp_rdata, 32'hCAFE_0001);
      accept();

      // 5: response backpressure with a second request held
      pready = 1'b1; prdata = 32'h0BAD_F00D;
      send(32'h0000_4000, 1'b0, 32'h0, 4'h0);
      tick();
      tick();
      chk("t5_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      req_addr = 32'h0000_5000; req_write = 1'b1; req_wdata = 32'h99; req_wstrb = 4'hF;
      req_valid = 1'b1;
      prdata = 32'h1111_1111;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("t5_bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("t5_bp_rdata", rsp_rdata, 32'h0BAD_F00D);
         chk("t5_bp_err", {31'd0, rsp_err}, 32'd0);
         chk("t5_bp_req_ready", {31'd0, req_ready}, 32'd0);
         chk("t5_bp_psel", {31'd0, psel}, 32'd0);
      end
      rsp_ready = 1'b1;
      tick();
      chk("t5_rel_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("t5_rel_req_ready", {31'd0, req_ready}, 32'd1);
      chk("t5_rel_psel", {31'd0, psel}, 32'd0);
      tick();
      req_valid = 1'b0;
      chk("t5_2nd_psel", {31'd0, psel}, 32'd1);
      chk("t5_2nd_paddr", paddr, 32'h0000_5000);
      chk("t5_2nd_pwstrb", {28'd0, pwstrb}, 32'hF);
      chk("t5_2nd_pwdata", pwdata, 32'h99);
      tick();
      tick();
      chk("t5_2nd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("t5_2nd_rdata", rsp_rdata, 32'h0);
      tick();
      chk("t5_2nd_done", {31'd0, rsp_valid}, 32'd0);
      rsp_ready = 1'b0;

      // 6: reset asserted during ACCESS
      pready = 1'b0;
      send(32'h0000_6000, 1'b0, 32'h0, 4'h0);
      tick();
      chk("t6_in_access", {31'd0, penable}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_psel", {31'd0, psel}, 32'd0);
      chk("t6_rst_penable", {31'd0, penable}, 32'd0);
      chk("t6_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("t6_rst_req_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("t6_post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("t6_post_req_ready", {31'd0, req_ready}, 32'd1);
      pready = 1'b1; prdata = 32'h600D_0006;
      send(32'h0000_6004, 1'b0, 32'h0, 4'h0);
      tick();
      tick();
      chk("t6_new_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("t6_new_rdata", rsp_rdata, 32'h600D_0006);
      chk("t6_new_err", {31'd0, rsp_err}, 32'd0);
      accept();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
